mac_share_arbiter: RTL and testbench

- Shares one piped_mac instance between NUM_REQ independent AXI-Stream requesters.
- Each request packet carries one bias on TUSER plus a sequence of packed int8 weight/activation beats, ending on TLAST.
- Grants packets round-robin, locks the grant for a whole packet, and records the owner ID in an in-order ID FIFO.
- Steers each 32-bit MAC result back to the requester that issued the packet. Sits between the layer sequencers and the MAC.

---
 rtl/mac_share_arbiter_pkg.sv | 21 ++
 rtl/mac_share_arbiter_if.sv | 34 +++
 rtl/mac_share_arbiter_id_fifo.sv | 51 +++++
 rtl/mac_share_arbiter.sv | 72 +++++++
 tb/tb_mac_share_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_share_arbiter_pkg.sv
// mac_arb_pkg: shared widths, arbiter state and round-robin pick for the MAC share arbiter
package mac_arb_pkg;
  localparam int DATA_W = 16;
  localparam int ACC_W = 32;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic logic [2:0] rr_pick(input logic [7:0] v, input logic [2:0] ptr, input int n);
    logic [2:0] r;
    logic f;
    logic [3:0] k;
    r = ptr;
    f = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k = (4'(ptr) + 4'(i)) % 4'(n);
      if (!f && i < n && k[3] == 1'b0 && v[k[2:0]]) begin
        r = k[2:0];
        f = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mac_share_arbiter_if.sv
// mac_share_arbiter_if: requester, MAC and result streams around the shared MAC
interface mac_share_arbiter_if #(parameter int NUM_REQ = 4);
  import mac_arb_pkg::*;
  logic [NUM_REQ-1:0] S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [NUM_REQ*DATA_W-1:0] S_AXIS_TDATA;
  logic [NUM_REQ*ACC_W-1:0] S_AXIS_TUSER;
  logic MAC_AXIS_TVALID, MAC_AXIS_TREADY, MAC_AXIS_TLAST;
  logic [DATA_W-1:0] MAC_AXIS_TDATA;
  logic [ACC_W-1:0] MAC_AXIS_TUSER;
  logic MACR_AXIS_TVALID, MACR_AXIS_TREADY, MACR_AXIS_TLAST;
  logic [ACC_W-1:0] MACR_AXIS_TDATA;
  logic [NUM_REQ-1:0] M_AXIS_TVALID, M_AXIS_TREADY;
  logic [ACC_W-1:0] M_AXIS_TDATA;
  modport slave (
    input S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TUSER, S_AXIS_TLAST,
    output S_AXIS_TREADY,
    output MAC_AXIS_TVALID, MAC_AXIS_TDATA, MAC_AXIS_TUSER, MAC_AXIS_TLAST,
    input MAC_AXIS_TREADY,
    input MACR_AXIS_TVALID, MACR_AXIS_TDATA,
    output MACR_AXIS_TREADY,
    output M_AXIS_TVALID, M_AXIS_TDATA,
    input M_AXIS_TREADY
  );
  modport master (
    output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TUSER, S_AXIS_TLAST,
    input S_AXIS_TREADY,
    input MAC_AXIS_TVALID, MAC_AXIS_TDATA, MAC_AXIS_TUSER, MAC_AXIS_TLAST,
    output MAC_AXIS_TREADY,
    output MACR_AXIS_TVALID, MACR_AXIS_TDATA, MACR_AXIS_TLAST,
    input MACR_AXIS_TREADY,
    input M_AXIS_TVALID, M_AXIS_TDATA,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/mac_share_arbiter_id_fifo.sv
// mac_id_fifo: in-order FIFO of requester IDs for packets in flight inside the MAC
module mac_id_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  import mac_arb_pkg::*;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem_q[rd_q];
  assign count = cnt_q;
  // advance pointers and occupancy; simultaneous push and pop cancel in the count
  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset, occupancy guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin packet arbiter sharing one MAC, returning results in order
module mac_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_FIFO_DEPTH = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(ID_FIFO_DEPTH) + 1
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  mac_share_arbiter_if.slave   bus,
  output logic [IW-1:0]        BUSY_ID,
  output logic [CW-1:0]        FIFO_CNT
);
  import mac_arb_pkg::*;
  arb_state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, head;
  logic [7:0] vld8;
  logic in_grant, push, pop, full, empty;
  assign in_grant = state_q == GRANT;
  assign bus.MAC_AXIS_TVALID = in_grant && bus.S_AXIS_TVALID[grant_q];
  assign bus.MAC_AXIS_TDATA = bus.S_AXIS_TDATA[grant_q*DATA_W +: DATA_W];
  assign bus.MAC_AXIS_TUSER = bus.S_AXIS_TUSER[grant_q*ACC_W +: ACC_W];
  assign bus.MAC_AXIS_TLAST = bus.S_AXIS_TLAST[grant_q];
  assign bus.S_AXIS_TREADY = in_grant && bus.MAC_AXIS_TREADY ? NUM_REQ'(1) << grant_q : '0;
  assign push = bus.MAC_AXIS_TVALID && bus.MAC_AXIS_TREADY && bus.MAC_AXIS_TLAST;
  assign bus.M_AXIS_TVALID = !empty && bus.MACR_AXIS_TVALID ? NUM_REQ'(1) << head : '0;
  assign bus.MACR_AXIS_TREADY = !empty && bus.M_AXIS_TREADY[head];
  assign bus.M_AXIS_TDATA = bus.MACR_AXIS_TDATA;
  assign pop = bus.MACR_AXIS_TVALID && bus.MACR_AXIS_TREADY;
  assign BUSY_ID = grant_q;
  // widen the valid vector to the fixed width the picker works on
  always_comb begin
    vld8 = '0;
    vld8[NUM_REQ-1:0] = bus.S_AXIS_TVALID;
  end
  // grant a packet only when its result has a FIFO slot; release on the last beat
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (!in_grant && |bus.S_AXIS_TVALID && !full) begin
      state_d = GRANT;
      grant_d = IW'(rr_pick(vld8, 3'(rr_ptr_q), NUM_REQ));
    end else if (push) begin
      state_d = IDLE;
      rr_ptr_d = grant_q == IW'(NUM_REQ - 1) ? '0 : grant_q + 1'b1;
    end
  end
  // arbiter FSM registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  mac_id_fifo #(.W(IW), .DEPTH(ID_FIFO_DEPTH)) u_id_fifo (
    .clk(ACLK),
    .rst(ARESET),
    .push(push),
    .pop(pop),
    .din(grant_q),
    .head(head),
    .count(FIFO_CNT),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_mac_share_arbiter.sv
// tb_mac_share_arbiter: scoreboard bench with a behavioural MAC behind the arbiter
module tb_mac_share_arbiter;
  import mac_arb_pkg::*;
  localparam int N = 4;
  typedef struct packed {logic [15:0] d; logic [31:0] b; logic l;} beat_t;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [1:0] busy_id;
  logic [2:0] fifo_cnt;
  mac_share_arbiter_if #(.NUM_REQ(N)) bus();
  mac_share_arbiter #(.NUM_REQ(N), .ID_FIFO_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .BUSY_ID(busy_id), .FIFO_CNT(fifo_cnt)
  );
  always #5 ACLK = ~ACLK;
  beat_t beat_q[N][$];
  int exp_q[N][$];
  int res_log[$], gnt_log[$];
  int last_by[N];
  int mac_q[$];
  int acc = 0;
  logic first = 1'b1;
  logic [N-1:0] drv_v = '0, drv_l = '0, hold = '0, m_rdy = '1;
  logic [N*16-1:0] drv_d = '0;
  logic [N*32-1:0] drv_u = '0;
  logic mac_rdy = 1'b1, macr_v = 1'b0;
  logic [31:0] macr_d = '0;
  int n_chk = 0, n_pass = 0;
  assign bus.S_AXIS_TVALID = drv_v & ~hold;
  assign bus.S_AXIS_TDATA = drv_d;
  assign bus.S_AXIS_TUSER = drv_u;
  assign bus.S_AXIS_TLAST = drv_l;
  assign bus.M_AXIS_TREADY = m_rdy;
  assign bus.MAC_AXIS_TREADY = mac_rdy;
  assign bus.MACR_AXIS_TVALID = macr_v;
  assign bus.MACR_AXIS_TDATA = macr_d;
  assign bus.MACR_AXIS_TLAST = macr_v;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic add_beat(input int i, input int w, input int a, input int b, input bit l);
    beat_t t;
    t.d = {8'(w), 8'(a)};
    t.b = 32'(b);
    t.l = l;
    beat_q[i].push_back(t);
  endtask

  task automatic pkt1(input int i, input int b, input int w, input int a);
    add_beat(i, w, a, b, 1'b1);
    exp_q[i].push_back(b + w * a);
  endtask

  task automatic pkt2(input int i, input int b, input int w0, input int a0, input int w1, input int a1);
    add_beat(i, w0, a0, b, 1'b0);
    add_beat(i, w1, a1, b, 1'b1);
    exp_q[i].push_back(b + w0 * a0 + w1 * a1);
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < N; i++) p += beat_q[i].size() + exp_q[i].size();
    return p;
  endfunction

  function automatic int code(input int q[$]);
    int c = 0;
    foreach (q[k]) c = c * 10 + q[k] + 1;
    return c;
  endfunction

  task automatic drain(input string tag);
    for (int c = 0; c < 2000 && pending() != 0; c++) @(negedge ACLK);
    chk({"drain_", tag}, pending(), 0);
    repeat (3) @(negedge ACLK);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    hold = '0;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic clear_logs();
    res_log.delete();
    gnt_log.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_fifo_cnt"}, int'(fifo_cnt), 0);
    chk({tag, "_busy_id"}, int'(busy_id), 0);
    chk({tag, "_s_tready"}, int'(bus.S_AXIS_TREADY), 0);
    chk({tag, "_mac_tvalid"}, int'(bus.MAC_AXIS_TVALID), 0);
    chk({tag, "_m_tvalid"}, int'(bus.M_AXIS_TVALID), 0);
    chk({tag, "_macr_tready"}, int'(bus.MACR_AXIS_TREADY), 0);
  endtask

  // requester drivers: advance each beat queue on its handshake
  always @(posedge ACLK) begin
    for (int i = 0; i < N; i++) begin
      if (ARESET) beat_q[i].delete();
      else if (bus.S_AXIS_TVALID[i] && bus.S_AXIS_TREADY[i]) void'(beat_q[i].pop_front());
      if (beat_q[i].size() != 0) begin
        drv_v[i] <= 1'b1;
        drv_d[i*16 +: 16] <= beat_q[i][0].d;
        drv_u[i*32 +: 32] <= beat_q[i][0].b;
        drv_l[i] <= beat_q[i][0].l;
      end else begin
        drv_v[i] <= 1'b0;
        drv_l[i] <= 1'b0;
      end
    end
  end

  // behavioural piped_mac: bias + sum of signed int8 products, one result per packet
  always @(posedge ACLK) begin
    if (ARESET) begin
      mac_q.delete();
      first = 1'b1;
      acc = 0;
    end else begin
      if (macr_v && bus.MACR_AXIS_TREADY) void'(mac_q.pop_front());
      if (bus.MAC_AXIS_TVALID && mac_rdy) begin
        acc = (first ? int'(bus.MAC_AXIS_TUSER) : acc)
            + int'($signed(bus.MAC_AXIS_TDATA[15:8])) * int'($signed(bus.MAC_AXIS_TDATA[7:0]));
        first = bus.MAC_AXIS_TLAST;
        if (bus.MAC_AXIS_TLAST) mac_q.push_back(acc);
      end
    end
    macr_v <= mac_q.size() != 0;
    if (mac_q.size() != 0) macr_d <= mac_q[0];
  end

  // result monitor and grant log
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (!$onehot0(bus.M_AXIS_TVALID)) chk("m_tvalid_onehot", int'(bus.M_AXIS_TVALID), 0);
      if (!$onehot0(bus.S_AXIS_TREADY)) chk("s_tready_onehot", int'(bus.S_AXIS_TREADY), 0);
      for (int h = 0; h < N; h++) begin
        if (bus.M_AXIS_TVALID[h] && bus.M_AXIS_TREADY[h]) begin
          int e;
          e = exp_q[h].size() != 0 ? exp_q[h].pop_front() : 32'h7fff_ffff;
          chk($sformatf("result_req%0d", h), int'(bus.M_AXIS_TDATA), e);
          res_log.push_back(h);
          last_by[h] = int'(bus.M_AXIS_TDATA);
        end
      end
      if (bus.MAC_AXIS_TVALID && bus.MAC_AXIS_TREADY && bus.MAC_AXIS_TLAST) gnt_log.push_back(int'(busy_id));
    end
  end

  initial begin
    int c;
    repeat (3) @(negedge ACLK);
    chk_idle_outputs("reset");
    ARESET = 1'b0;
    // single requester
    clear_logs();
    pkt2(0, -600, -50, 38, 5, 2);
    drain("t1");
    chk("t1_result", last_by[0], -2490);
    chk("t1_nres", res_log.size(), 1);
    chk("t1_fifo_cnt", int'(fifo_cnt), 0);
    // two requesters at once
    clear_logs();
    pkt2(1, 5, -10, 5, 25, 100);
    pkt2(2, 99, 37, 3, 18, 23);
    drain("t2");
    chk("t2_grant_order", code(gnt_log), 23);
    chk("t2_result_order", code(res_log), 23);
    chk("t2_req1", last_by[1], 2455);
    chk("t2_req2", last_by[2], 624);
    // all four streaming from rr_ptr 0
    do_reset();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) pkt1(i, 5000, -128, -128);
    drain("t3");
    chk("t3_grants", code(gnt_log), 12341234);
    chk("t3_nres", res_log.size(), 8);
    chk("t3_req3", last_by[3], 21384);
    // result back-pressure fills the ID FIFO
    clear_logs();
    m_rdy[0] = 1'b0;
    for (int k = 0; k < 5; k++) pkt1(0, k * 100, k + 1, 3);
    c = 0;
    while (fifo_cnt != 3'd4 && c < 200) begin @(negedge ACLK); c++; end
    repeat (5) @(negedge ACLK);
    chk("t4_fifo_full", int'(fifo_cnt), 4);
    chk("t4_no_tready", int'(bus.S_AXIS_TREADY), 0);
    chk("t4_fifth_waiting", beat_q[0].size(), 1);
    chk("t4_mac_idle", int'(bus.MAC_AXIS_TVALID), 0);
    m_rdy = '1;
    drain("t4");
    chk("t4_nres", res_log.size(), 5);
    chk("t4_ngrant", gnt_log.size(), 5);
    chk("t4_fifo_empty", int'(fifo_cnt), 0);
    // mid-packet stall keeps the grant locked
    clear_logs();
    pkt2(3, -2000, -128, 127, -100, 120);
    c = 0;
    while (beat_q[3].size() != 1 && c < 100) begin @(negedge ACLK); c++; end
    chk("t5_first_beat", beat_q[3].size(), 1);
    hold[3] = 1'b1;
    pkt1(1, 1, 2, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      chk("t5_busy_id", int'(busy_id), 3);
      chk("t5_s_tready", int'(bus.S_AXIS_TREADY), 8);
      chk("t5_mac_tvalid", int'(bus.MAC_AXIS_TVALID), 0);
    end
    hold[3] = 1'b0;
    drain("t5");
    chk("t5_req3", last_by[3], -30256);
    chk("t5_order", code(res_log), 42);
    // reset in the middle of a packet
    clear_logs();
    add_beat(1, 4, 4, 77, 1'b0);
    add_beat(1, 5, 5, 77, 1'b1);
    c = 0;
    while (beat_q[1].size() != 1 && c < 100) begin @(negedge ACLK); c++; end
    chk("t6_half_sent", beat_q[1].size(), 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk_idle_outputs("t6");
    ARESET = 1'b0;
    pkt2(1, 7, 3, 4, -2, 9);
    drain("t6");
    chk("t6_req1", last_by[1], 1);
    chk("t6_nres", res_log.size(), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
